// File: rtl/norm_shift_ctrl_pkg.sv
// Shared definitions for the FP add/sub normalization controller:
// hi/lo split of the significand magnitude, shift direction and fill encodings.
package norm_shift_ctrl_pkg;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  localparam logic FILL_BIT = 1'b0;

  // Upper half gets the extra bit when SWR-1 is odd: ceil((SWR-1)/2).
  function automatic int hi_width(input int swr);
    return swr / 2;
  endfunction

  function automatic int lo_width(input int swr);
    return (swr - 1) - (swr / 2);
  endfunction

endpackage

// File: rtl/norm_shift_ctrl_lzd_group.sv
// Combinational leading-zero detector for one group of bits.
// cnt_o = W when the whole group is zero.
module lzd_group #(
  parameter int W  = 13,
  parameter int CW = 4
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  // Priority encode: the highest set bit is visited last and wins.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) begin
        cnt_o = CW'(W - 1 - i);
      end else begin
        cnt_o = cnt_o;
      end
    end
  end

  assign zero_o = ~|in_i;

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalization controller: leading-one detect in stage 1, shift command
// and exponent adjustment in stage 2, one result per cycle.
module norm_shift_ctrl
  import norm_shift_ctrl_pkg::*;
#(
  parameter int SWR = 26,
  parameter int EWR = 5,
  parameter int EW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [SWR-1:0] Data_i,
  input  logic [EW-1:0]  Exp_i,
  output logic [EWR-1:0] Shift_Value_o,
  output logic           FSM_left_right_o,
  output logic           bit_shift_o,
  output logic [EW-1:0]  Exp_o,
  output logic           zero_o,
  output logic           overflow_o,
  output logic           underflow_o,
  output logic           load_o
);

  localparam int H   = hi_width(SWR);
  localparam int L   = lo_width(SWR);
  localparam int HCW = $clog2(H + 1);
  localparam int LCW = $clog2(L + 1);
  localparam logic [EW-1:0] EXP_MAX = '1;

  logic [HCW-1:0] hi_lz_s;
  logic [LCW-1:0] lo_lz_s;
  logic           hi_zero_s, lo_zero_s;

  lzd_group #(.W(H), .CW(HCW)) u_lzd_hi (
    .in_i   (Data_i[SWR-2 -: H]),
    .cnt_o  (hi_lz_s),
    .zero_o (hi_zero_s)
  );

  lzd_group #(.W(L), .CW(LCW)) u_lzd_lo (
    .in_i   (Data_i[L-1:0]),
    .cnt_o  (lo_lz_s),
    .zero_o (lo_zero_s)
  );

  logic           v1_q, v1_d;
  logic           c_q, c_d;
  logic [EW-1:0]  exp1_q, exp1_d;
  logic [HCW-1:0] hi_lz_q, hi_lz_d;
  logic [LCW-1:0] lo_lz_q, lo_lz_d;
  logic           hi_zero_q, hi_zero_d;
  logic           lo_zero_q, lo_zero_d;

  // Stage 1 capture; data registers hold while no load is presented.
  always_comb begin
    v1_d      = load_i;
    c_d       = c_q;
    exp1_d    = exp1_q;
    hi_lz_d   = hi_lz_q;
    lo_lz_d   = lo_lz_q;
    hi_zero_d = hi_zero_q;
    lo_zero_d = lo_zero_q;
    if (load_i) begin
      c_d       = Data_i[SWR-1];
      exp1_d    = Exp_i;
      hi_lz_d   = hi_lz_s;
      lo_lz_d   = lo_lz_s;
      hi_zero_d = hi_zero_s;
      lo_zero_d = lo_zero_s;
    end else begin
      v1_d = 1'b0;
    end
  end

  logic [EWR-1:0] shift_q, shift_d;
  logic           dir_q, dir_d;
  logic           fill_q, fill_d;
  logic [EW-1:0]  exp_q, exp_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           load_q, load_d;

  logic [EWR-1:0] lz_s;
  logic [EW:0]    exp_inc_s, exp_sub_s;

  // Stage 2 decision; carry beats the leading-zero path, outputs hold when idle.
  always_comb begin
    lz_s      = hi_zero_q ? (EWR'(H) + EWR'(lo_lz_q)) : EWR'(hi_lz_q);
    exp_inc_s = {1'b0, exp1_q} + (EW+1)'(1);
    exp_sub_s = {1'b0, exp1_q} - (EW+1)'(lz_s);
    shift_d   = shift_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    exp_d     = exp_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    load_d    = 1'b0;
    if (v1_q) begin
      load_d = 1'b1;
      fill_d = FILL_BIT;
      zero_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      if (c_q) begin
        dir_d   = DIR_RIGHT;
        shift_d = EWR'(1);
        if (exp_inc_s >= {1'b0, EXP_MAX}) begin
          ovf_d = 1'b1;
          exp_d = EXP_MAX;
        end else begin
          exp_d = exp_inc_s[EW-1:0];
        end
      end else if (hi_zero_q && lo_zero_q) begin
        zero_d  = 1'b1;
        dir_d   = DIR_LEFT;
        shift_d = '0;
        exp_d   = '0;
      end else begin
        dir_d   = DIR_LEFT;
        shift_d = lz_s;
        // Borrow out of the widened subtraction means lz > Exp.
        if (exp_sub_s[EW]) begin
          unf_d = 1'b1;
          exp_d = '0;
        end else begin
          exp_d = exp_sub_s[EW-1:0];
        end
      end
    end else begin
      load_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      c_q       <= 1'b0;
      exp1_q    <= '0;
      hi_lz_q   <= '0;
      lo_lz_q   <= '0;
      hi_zero_q <= 1'b0;
      lo_zero_q <= 1'b0;
      shift_q   <= '0;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
      exp_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      c_q       <= c_d;
      exp1_q    <= exp1_d;
      hi_lz_q   <= hi_lz_d;
      lo_lz_q   <= lo_lz_d;
      hi_zero_q <= hi_zero_d;
      lo_zero_q <= lo_zero_d;
      shift_q   <= shift_d;
      dir_q     <= dir_d;
      fill_q    <= fill_d;
      exp_q     <= exp_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      load_q    <= load_d;
    end
  end

  assign Shift_Value_o    = shift_q;
  assign FSM_left_right_o = dir_q;
  assign bit_shift_o      = fill_q;
  assign Exp_o            = exp_q;
  assign zero_o           = zero_q;
  assign overflow_o       = ovf_q;
  assign underflow_o      = unf_q;
  assign load_o           = load_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Directed, table-driven bench for norm_shift_ctrl (SWR=26, EWR=5, EW=8).
module tb_norm_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i;
  logic [25:0] Data_i;
  logic [7:0]  Exp_i;
  logic [4:0]  Shift_Value_o;
  logic        FSM_left_right_o;
  logic        bit_shift_o;
  logic [7:0]  Exp_o;
  logic        zero_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        load_o;

  int n_cmp = 0;
  int n_err = 0;

  norm_shift_ctrl #(.SWR(26), .EWR(5), .EW(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .load_i           (load_i),
    .Data_i           (Data_i),
    .Exp_i            (Exp_i),
    .Shift_Value_o    (Shift_Value_o),
    .FSM_left_right_o (FSM_left_right_o),
    .bit_shift_o      (bit_shift_o),
    .Exp_o            (Exp_o),
    .zero_o           (zero_o),
    .overflow_o       (overflow_o),
    .underflow_o      (underflow_o),
    .load_o           (load_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] data;
    logic [7:0]  exp;
    logic [4:0]  shift;
    logic        lr;
    logic [7:0]  exp_o;
    logic        zero;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".load"},  32'(load_o), 32'd1);
    chk({p, ".shift"}, 32'(Shift_Value_o), 32'(v.shift));
    chk({p, ".lr"},    32'(FSM_left_right_o), 32'(v.lr));
    chk({p, ".fill"},  32'(bit_shift_o), 32'd0);
    chk({p, ".exp"},   32'(Exp_o), 32'(v.exp_o));
    chk({p, ".zero"},  32'(zero_o), 32'(v.zero));
    chk({p, ".ovf"},   32'(overflow_o), 32'(v.ovf));
    chk({p, ".unf"},   32'(underflow_o), 32'(v.unf));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".load"},  32'(load_o), 32'd0);
    chk({nm, ".shift"}, 32'(Shift_Value_o), 32'd0);
    chk({nm, ".lr"},    32'(FSM_left_right_o), 32'd0);
    chk({nm, ".fill"},  32'(bit_shift_o), 32'd0);
    chk({nm, ".exp"},   32'(Exp_o), 32'd0);
    chk({nm, ".zero"},  32'(zero_o), 32'd0);
    chk({nm, ".ovf"},   32'(overflow_o), 32'd0);
    chk({nm, ".unf"},   32'(underflow_o), 32'd0);
  endtask

  task automatic drive(input logic ld, input logic [25:0] d, input logic [7:0] e);
    load_i = ld;
    Data_i = d;
    Exp_i  = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            data          exp    shift lr exp_o  zero ovf unf
    vecs[0]  = '{26'h2000000, 8'd100, 5'd1,  1'b0, 8'd101, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{26'h1000000, 8'd100, 5'd0,  1'b1, 8'd100, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{26'h0000001, 8'd100, 5'd24, 1'b1, 8'd76,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{26'h0000800, 8'd100, 5'd13, 1'b1, 8'd87,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{26'h0000000, 8'd100, 5'd0,  1'b1, 8'd0,   1'b1, 1'b0, 1'b0};
    vecs[5]  = '{26'h0000400, 8'd5,   5'd14, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1};
    vecs[6]  = '{26'h2000000, 8'd254, 5'd1,  1'b0, 8'd255, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{26'h2000000, 8'd255, 5'd1,  1'b0, 8'd255, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{26'h2000000, 8'd253, 5'd1,  1'b0, 8'd254, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{26'h0000400, 8'd14,  5'd14, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0};
    vecs[10] = '{26'h3FFFFFF, 8'd100, 5'd1,  1'b0, 8'd101, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{26'h0001000, 8'd100, 5'd12, 1'b1, 8'd88,  1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 26'h0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single loads: result after the second edge, then a one-cycle strobe with held data.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].data, vecs[i].exp);
      @(posedge clk);
      #1;
      drive(1'b0, 26'h155_5555, 8'd3);
      chk($sformatf("v%0d.early", i), 32'(load_o), 32'd0);
      @(posedge clk);
      #1;
      chk_vec(i, vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.strobe", i), 32'(load_o), 32'd0);
      chk($sformatf("v%0d.hold", i), 32'(Exp_o), 32'(vecs[i].exp_o));
    end

    // Three back-to-back loads.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vecs[i + 2].data, vecs[i + 2].exp);
      @(posedge clk);
      #1;
      if (i >= 1) chk_vec(100 + i - 1, vecs[i + 1]);
    end
    drive(1'b0, 26'h0, 8'd0);
    @(posedge clk);
    #1;
    chk_vec(102, vecs[4]);
    @(posedge clk);
    #1;
    chk("b2b.end", 32'(load_o), 32'd0);

    // Reset the cycle after the second load: first result emerges, second is dropped.
    drive(1'b1, vecs[0].data, vecs[0].exp);
    @(posedge clk);
    #1;
    drive(1'b1, vecs[2].data, vecs[2].exp);
    @(posedge clk);
    #1;
    chk_vec(200, vecs[0]);
    drive(1'b0, 26'h0, 8'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_after");
    @(posedge clk);
    #1;
    chk("rst_drop", 32'(load_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
